cache_miss_arbiter: RTL and testbench

CACHE_MISS_ARBITER -- requirements
Module: cache_miss_arbiter

---
 rtl/cache_pkg.sv | 18 +
 rtl/word_counter.sv | 23 ++
 rtl/cache_miss_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cache_miss_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default sizing for the I/D cache miss arbiter.
package cache_pkg;

    localparam int BLOCK_WORDS_DEF = 8;
    localparam int ADDR_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_t;

endpackage

// File: rtl/word_counter.sv
// Up-counter with enable and synchronous clear; used for issue and return word offsets.
module word_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_miss_arbiter.sv
// Arbitrates I/D cache misses onto one pipelined memory read port and streams
// the returned block into the granted cache's data array, then writes its tag.
module cache_miss_arbiter
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    output logic                           i_stall,
    output logic                           d_stall,
    output logic                           mem_en,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic                           mem_data_valid,
    input  logic [15:0]                    mem_data,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           i_data_we,
    output logic                           d_data_we,
    output logic                           i_tag_we,
    output logic                           d_tag_we
);

    localparam int            CW   = $clog2(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W - 4){1'b1}}, 4'b0000};

    state_t            state, state_next;
    logic              grant_valid;
    req_t              grant_req;
    logic              grant_i, grant_d;
    logic [ADDR_W-1:0] base;
    logic              issue_done;
    logic [CW-1:0]     issue_cnt, ret_cnt;

    logic              take_grant;
    req_t              take_req;
    logic [ADDR_W-1:0] take_addr;
    logic              issue_en, ret_en, cnt_clr;

    assign grant_i   = grant_valid && (grant_req == REQ_I);
    assign grant_d   = grant_valid && (grant_req == REQ_D);
    assign fill_word = ret_cnt;

    word_counter #(.W(CW)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue_en),
        .clr   (cnt_clr),
        .cnt   (issue_cnt)
    );

    word_counter #(.W(CW)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ret_en),
        .clr   (cnt_clr),
        .cnt   (ret_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, block base and the "all words issued" flag live for one whole fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_valid <= 1'b0;
            grant_req   <= REQ_I;
            base        <= '0;
            issue_done  <= 1'b0;
        end else if (take_grant) begin
            grant_valid <= 1'b1;
            grant_req   <= take_req;
            base        <= take_addr & BASE_MASK;
        end else if (state == DONE) begin
            grant_valid <= 1'b0;
            issue_done  <= 1'b0;
        end else if (mem_en && (issue_cnt == LAST)) begin
            issue_done  <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_next = state;
        take_grant = 1'b0;
        take_req   = REQ_I;
        take_addr  = i_miss_addr;
        issue_en   = 1'b0;
        ret_en     = 1'b0;
        cnt_clr    = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        fill_data  = '0;
        i_data_we  = 1'b0;
        d_data_we  = 1'b0;
        i_tag_we   = 1'b0;
        d_tag_we   = 1'b0;

        case (state)
            IDLE: begin
                if (d_miss) begin
                    take_grant = 1'b1;
                    take_req   = REQ_D;
                    take_addr  = d_miss_addr;
                    state_next = FILL;
                end else if (i_miss) begin
                    take_grant = 1'b1;
                    take_req   = REQ_I;
                    take_addr  = i_miss_addr;
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_en = !issue_done;
                if (mem_en) begin
                    mem_addr = base + (ADDR_W'(issue_cnt) << 1);
                    issue_en = (issue_cnt != LAST);
                end
                fill_data = mem_data;
                if (mem_data_valid) begin
                    i_data_we = grant_i;
                    d_data_we = grant_d;
                    if (ret_cnt == LAST) begin
                        state_next = DONE;
                    end else begin
                        ret_en = 1'b1;
                    end
                end
            end
            DONE: begin
                i_tag_we   = grant_i;
                d_tag_we   = grant_d;
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The granted requester is released in DONE, the same cycle its tag is written.
    always_comb begin
        i_stall = i_miss | grant_i;
        d_stall = d_miss | grant_d;
        if (state == DONE) begin
            if (grant_i) i_stall = 1'b0;
            if (grant_d) d_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Self-checking bench: pipelined memory model, behavioural arbiter model, directed and random stimulus.
module tb_cache_miss_arbiter;

    localparam int BW = 8;
    localparam int AW = 16;

    localparam int M_IDLE = 0, M_FILL = 1, M_DONE = 2;
    localparam int W_NONE = 0, W_I = 1, W_D = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_miss, d_miss;
    logic [AW-1:0] i_miss_addr, d_miss_addr;
    logic          i_stall, d_stall;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic          mem_data_valid;
    logic [15:0]   mem_data;
    logic [15:0]   fill_data;
    logic [2:0]    fill_word;
    logic          i_data_we, d_data_we, i_tag_we, d_tag_we;

    always #5 clk = ~clk;

    cache_miss_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .i_stall        (i_stall),
        .d_stall        (d_stall),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .i_data_we      (i_data_we),
        .d_data_we      (d_data_we),
        .i_tag_we       (i_tag_we),
        .d_tag_we       (d_tag_we)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which requester owns the port, and how many words went out / came back.
    int            mst, who, issued, returned;
    logic [AW-1:0] m_base;
    bit            exp_itag, exp_dtag;

    task automatic model_reset();
        mst = M_IDLE; who = W_NONE; issued = 0; returned = 0; m_base = '0;
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (mst)
            M_IDLE: begin
                if (d_miss) begin
                    who = W_D; m_base = d_miss_addr & 16'hFFF0; mst = M_FILL;
                end else if (i_miss) begin
                    who = W_I; m_base = i_miss_addr & 16'hFFF0; mst = M_FILL;
                end
            end
            M_FILL: begin
                if (mem_data_valid) begin
                    if (returned == BW - 1) mst = M_DONE;
                    returned++;
                end
                if (issued < BW) issued++;
            end
            default: model_reset();
        endcase
    endtask

    task automatic compare_outputs();
        bit            e_en, e_iwe, e_dwe, e_istall, e_dstall;
        logic [AW-1:0] e_addr;
        int            e_fw;
        e_en     = (mst == M_FILL) && (issued < BW);
        e_addr   = e_en ? AW'(m_base + 2 * issued) : '0;
        e_iwe    = (mst == M_FILL) && mem_data_valid && (who == W_I);
        e_dwe    = (mst == M_FILL) && mem_data_valid && (who == W_D);
        exp_itag = (mst == M_DONE) && (who == W_I);
        exp_dtag = (mst == M_DONE) && (who == W_D);
        e_fw     = (returned > BW - 1) ? BW - 1 : returned;
        e_istall = exp_itag ? 1'b0 : (i_miss || who == W_I);
        e_dstall = exp_dtag ? 1'b0 : (d_miss || who == W_D);
        check("mem_en", mem_en, e_en);
        check("mem_addr", mem_addr, e_addr);
        check("i_data_we", i_data_we, e_iwe);
        check("d_data_we", d_data_we, e_dwe);
        check("i_tag_we", i_tag_we, exp_itag);
        check("d_tag_we", d_tag_we, exp_dtag);
        check("fill_word", fill_word, e_fw);
        check("i_stall", i_stall, e_istall);
        check("d_stall", d_stall, e_dstall);
        if (e_iwe || e_dwe) check("fill_data", fill_data, mem_data);
        else if (!rst_n)    check("fill_data_rst", fill_data, 0);
    endtask

    // Memory: each strobe returns its word a fixed number of cycles later, in order.
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } resp_t;

    resp_t rq[$];
    int    lat   = 4;
    bit    stray = 1'b0;
    int    cyc   = 0;

    function automatic logic [15:0] mem_fn(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    logic [AW-1:0] iss_addr_q[$];
    int            iss_cyc_q[$], iwe_q[$], dwe_q[$];
    int            itag_n, dtag_n, dtag_cyc, dwe_cyc0;
    logic          dstall_at_tag;

    task automatic clear_logs();
        iss_addr_q.delete(); iss_cyc_q.delete(); iwe_q.delete(); dwe_q.delete();
        itag_n = 0; dtag_n = 0; dtag_cyc = -1; dwe_cyc0 = -1; dstall_at_tag = 1'bx;
    endtask

    // One clock cycle: entered at a falling edge with requester inputs already set.
    task automatic step();
        resp_t r;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            mem_data_valid = 1'b1;
            mem_data       = mem_fn(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            mem_data_valid = stray;
            mem_data       = 16'($urandom);
        end
        #1;
        compare_outputs();
        if (mem_en) begin
            r.cyc = cyc + lat; r.addr = mem_addr;
            rq.push_back(r);
            iss_addr_q.push_back(mem_addr);
            iss_cyc_q.push_back(cyc);
        end
        if (i_data_we) iwe_q.push_back(int'(fill_word));
        if (d_data_we) begin
            if (dwe_q.size() == 0) dwe_cyc0 = cyc;
            dwe_q.push_back(int'(fill_word));
        end
        if (i_tag_we) itag_n++;
        if (d_tag_we) begin
            dtag_n++; dtag_cyc = cyc; dstall_at_tag = d_stall;
        end
        model_advance();
        @(negedge clk);
        cyc++;
        if (exp_itag) i_miss = 1'b0;
        if (exp_dtag) d_miss = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        do begin
            step(); n++;
        end while ((mst != M_IDLE || i_miss || d_miss) && n < budget);
        check("idle_reached", (mst == M_IDLE && !i_miss && !d_miss), 1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked before any clock edge.
    task automatic do_reset();
        stray = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_outputs();
        i_miss = 1'b0; d_miss = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        while (rq.size() > 0) step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; mem_data_valid = 1'b0; mem_data = '0;
        model_reset(); clear_logs();
        #2;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fill_word", fill_word, 0);
        check("rst_stall", {i_stall, d_stall}, 0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // Lone D miss at 0x1234 with a 4-cycle memory.
        clear_logs(); lat = 4;
        d_miss = 1'b1; d_miss_addr = 16'h1234;
        run_idle(60);
        check("s1_issue_count", iss_addr_q.size(), 8);
        if (iss_addr_q.size() == 8) begin
            check("s1_first_addr", iss_addr_q[0], 16'h1230);
            check("s1_last_addr", iss_addr_q[7], 16'h123E);
            check("s1_issue_span", iss_cyc_q[7] - iss_cyc_q[0], 7);
            check("s1_latency", dwe_cyc0 - iss_cyc_q[0], 4);
        end
        check("s1_dwe_count", dwe_q.size(), 8);
        foreach (dwe_q[i]) check("s1_fill_word_seq", dwe_q[i], i);
        check("s1_dtag_count", dtag_n, 1);
        check("s1_dstall_in_done", dstall_at_tag, 0);

        // Simultaneous misses: D first, I granted right after DONE.
        clear_logs();
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'h8000;
        run_idle(120);
        check("s2_issue_count", iss_addr_q.size(), 16);
        if (iss_addr_q.size() == 16) begin
            check("s2_d_first", iss_addr_q[0], 16'h8000);
            check("s2_d_last", iss_addr_q[7], 16'h800E);
            check("s2_i_first", iss_addr_q[8], 16'h0040);
            check("s2_i_after_done", iss_cyc_q[8] - dtag_cyc, 2);
        end

        // I granted, D raised mid-fill: no preemption.
        clear_logs();
        i_miss = 1'b1; i_miss_addr = 16'h0100;
        repeat (3) step();
        d_miss = 1'b1; d_miss_addr = 16'h2200;
        run_idle(120);
        check("s3_iwe_count", iwe_q.size(), 8);
        if (iss_addr_q.size() == 16) begin
            check("s3_i_last", iss_addr_q[7], 16'h010E);
            check("s3_d_first", iss_addr_q[8], 16'h2200);
        end else begin
            check("s3_issue_count", iss_addr_q.size(), 16);
        end
        check("s3_tags", {itag_n[3:0], dtag_n[3:0]}, 8'h11);

        // Reset after the third returned word, then a clean restart.
        clear_logs();
        d_miss = 1'b1; d_miss_addr = 16'h3456;
        begin
            int n = 0;
            while (dwe_q.size() < 3 && n < 50) begin step(); n++; end
        end
        check("s4_three_words", dwe_q.size(), 3);
        do_reset();
        check("s4_no_tag", dtag_n + itag_n, 0);
        clear_logs();
        d_miss = 1'b1; d_miss_addr = 16'h3456;
        run_idle(60);
        check("s4_restart_count", dwe_q.size(), 8);
        if (dwe_q.size() > 0) check("s4_restart_word0", dwe_q[0], 0);
        if (iss_addr_q.size() > 0) check("s4_restart_addr", iss_addr_q[0], 16'h3450);

        // Stray read data in IDLE.
        clear_logs();
        stray = 1'b1;
        repeat (4) step();
        stray = 1'b0;
        check("s5_no_we", iwe_q.size() + dwe_q.size(), 0);
        check("s5_fill_word", fill_word, 0);

        // I miss dropped after two words still completes and tags.
        clear_logs();
        i_miss = 1'b1; i_miss_addr = 16'h0A0A;
        begin
            int n = 0;
            while (iwe_q.size() < 2 && n < 50) begin step(); n++; end
        end
        i_miss = 1'b0;
        run_idle(60);
        check("s6_iwe_count", iwe_q.size(), 8);
        check("s6_itag", itag_n, 1);
        if (iss_addr_q.size() > 0) check("s6_base", iss_addr_q[0], 16'h0A00);

        // Random traffic, drops, strays and occasional resets.
        lat = $urandom_range(1, 6);
        for (int k = 0; k < 3000; k++) begin
            if (!i_miss && who != W_I && $urandom_range(0, 7) == 0) begin
                i_miss = 1'b1; i_miss_addr = AW'($urandom);
            end
            if (!d_miss && who != W_D && $urandom_range(0, 7) == 0) begin
                d_miss = 1'b1; d_miss_addr = AW'($urandom);
            end
            if (who == W_I && i_miss && $urandom_range(0, 39) == 0) i_miss = 1'b0;
            if (who == W_D && d_miss && $urandom_range(0, 39) == 0) d_miss = 1'b0;
            stray = (mst == M_IDLE) && (rq.size() == 0) && ($urandom_range(0, 9) == 0);
            step();
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                lat = $urandom_range(1, 6);
            end
        end
        stray = 1'b0;
        run_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
